// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a grant hold counter and forced release.
// gnt_idx is registered and intended to feed a 3-to-8 decoder gated by gnt_valid.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam bit            HoldEnable = (HOLD_MAX != 0);
  localparam logic [CW-1:0] HoldLast   = (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);

  state_e        state_q;
  logic [2:0]    ptr_q;
  logic [2:0]    gntIdx_q;
  logic          gntValid_q;
  logic          timeout_q;
  logic [CW-1:0] holdCnt_q;
  logic [CW-1:0] holdCnt_d;

  logic [7:0]    rotated;
  logic [2:0]    offset;
  logic [2:0]    pick;
  logic          normalEnd;
  logic          forcedEnd;

  // Rotate the request vector so bit 0 is the current highest-priority slot,
  // then take the lowest set bit and map it back to an absolute index.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < 8; i++) begin
      rotated[i] = req[ptr_q + 3'(i)];
    end
    offset = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = 3'(i);
      end
    end
    pick = ptr_q + offset;
  end

  // Release or a dropped request always takes precedence over the timeout.
  always_comb begin
    normalEnd = release_i || !req[gntIdx_q];
    forcedEnd = HoldEnable && (holdCnt_q == HoldLast);
    holdCnt_d = (holdCnt_q == '1) ? holdCnt_q : holdCnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      gntIdx_q   <= 3'd0;
      gntValid_q <= 1'b0;
      timeout_q  <= 1'b0;
      holdCnt_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gntValid_q <= 1'b0;
          if (|req) begin
            gntIdx_q   <= pick;
            gntValid_q <= 1'b1;
            holdCnt_q  <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (normalEnd || forcedEnd) begin
            gntValid_q <= 1'b0;
            ptr_q      <= gntIdx_q + 3'd1;
            timeout_q  <= ~normalEnd;
            state_q    <= IDLE;
          end else begin
            holdCnt_q <= holdCnt_d;
          end
        end
        default: begin
          gntValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign gnt_valid = gntValid_q;
  assign gnt_idx   = gntIdx_q;
  assign timeout   = timeout_q;

endmodule
